// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared widths, config-field indices, FSM states and
// channel decode for the emulated LTC2308-style serial ADC responder.
package adc_resp_pkg;

  localparam int DATA_W = 12;
  localparam int CFG_W  = 6;
  localparam int N_CH   = 8;

  // Config word, MSB first on the wire: {SD,OS,S1,S0,UNI,SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // CH0, single-ended, unipolar, awake
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CONV
  } state_t;

  function automatic logic [2:0] cfg_to_channel(
    input logic [CFG_W-1:0] c
  );
    return {c[CFG_S1], c[CFG_S0], c[CFG_OS]};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchroniser with rise/fall pulses on the synced value.
// Ports: i_clk, i_rst (async high), i_d (async in), o_q (synced), o_rise, o_fall.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: device end of the 4-wire serial ADC link, emulating
// an 8-channel 12-bit converter. Inputs: clk, reset, adc_sclk, adc_cs_n,
// adc_din, ch_data, err_clear. Outputs: adc_dout, cfg_valid, cfg_word,
// cfg_channel, frame_err.
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int CONV_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adc_sclk,
  input  logic                   adc_cs_n,
  input  logic                   adc_din,
  output logic                   adc_dout,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic                   cfg_valid,
  output logic [CFG_W-1:0]       cfg_word,
  output logic [2:0]             cfg_channel,
  output logic                   frame_err,
  input  logic                   err_clear
);

  localparam int CW = $clog2(CONV_CYCLES);
  localparam logic [4:0] CFG_BITS = 5'(CFG_W);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_din, w_din_rise, w_din_fall;
  logic w_unused;

  sync_edge_det #(.RST_VAL(1'b0)) u_sclk (
    .i_clk(clk), .i_rst(reset), .i_d(adc_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_cs (
    .i_clk(clk), .i_rst(reset), .i_d(adc_cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_din (
    .i_clk(clk), .i_rst(reset), .i_d(adc_din),
    .o_q(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  assign w_unused = ^{w_sclk_q, w_din_rise, w_din_fall};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [CFG_W-1:0]   r_cfg_shift;
  logic [CFG_W-1:0]   r_cfg_word;
  logic [4:0]         r_bit_cnt;
  logic [CW-1:0]      r_conv_cnt;
  logic               r_cfg_valid;
  logic               r_frame_err;
  logic               w_load;
  logic               w_commit;
  logic               w_err_set;
  logic [2:0]         w_chan;
  logic [DATA_W-1:0]  w_ch [N_CH];
  logic [DATA_W-1:0]  w_load_val;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_ch[g] = ch_data[g*DATA_W +: DATA_W];
  end

  assign w_chan = cfg_to_channel(r_cfg_word);

  // Bipolar mode: flip MSB to turn offset-binary into two's complement
  always_comb begin
    w_load_val = w_ch[w_chan];
    if (!r_cfg_word[CFG_UNI]) begin
      w_load_val[DATA_W-1] = ~w_load_val[DATA_W-1];
    end
    if (r_cfg_word[CFG_SLP]) begin
      w_load_val = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = CONV;
          if (r_bit_cnt >= CFG_BITS) w_commit  = 1'b1;
          else                       w_err_set = 1'b1;
        end
      end
      CONV: begin
        // A master that re-selects too early still gets data
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = SHIFT;
        end else if (r_conv_cnt == CONV_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_cfg_shift <= '0;
      r_cfg_word  <= CFG_RESET;
      r_bit_cnt   <= '0;
      r_conv_cnt  <= '0;
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cfg_valid <= w_commit;
      if (w_commit) r_cfg_word <= r_cfg_shift;
      if (w_err_set)      r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
      if (r_state == CONV) r_conv_cnt <= r_conv_cnt + CW'(1);
      else                 r_conv_cnt <= '0;
      if (w_load) begin
        r_shift     <= w_load_val;
        r_cfg_shift <= '0;
        r_bit_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise) begin
          if (r_bit_cnt < CFG_BITS) begin
            r_cfg_shift <= {r_cfg_shift[CFG_W-2:0], w_din};
          end
          if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        if (w_sclk_fall) begin
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign adc_dout    = (r_state == SHIFT) & ~w_cs_q & r_shift[DATA_W-1];
  assign cfg_valid   = r_cfg_valid;
  assign cfg_word    = r_cfg_word;
  assign cfg_channel = w_chan;
  assign frame_err   = r_frame_err;

endmodule
